// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl.
// master: the datapath. It drives the ID/EX/MEM/WB stage fields and receives
//         the control outputs.
// slave : hazard_ctrl. It reads the stage fields and drives stall, flush,
//         forwarding and PC control, the FSM state and the performance counters.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_valid;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_is_mul;
  logic             br_taken;
  logic             mem_valid;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             wb_reg_write;

  logic             stall_flag;
  logic             pc_write;
  logic             if_id_write;
  logic             flush_if_id;
  logic             bubble_id_ex;
  logic             pc_sel;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt,
    output ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_is_mul, br_taken,
    output mem_valid, mem_rd, mem_reg_write,
    output wb_valid, wb_rd, wb_reg_write,
    input  stall_flag, pc_write, if_id_write, flush_if_id, bubble_id_ex, pc_sel,
    input  fwd_a, fwd_b, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt,
    input  ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_is_mul, br_taken,
    input  mem_valid, mem_rd, mem_reg_write,
    input  wb_valid, wb_rd, wb_reg_write,
    output stall_flag, pc_write, if_id_write, flush_if_id, bubble_id_ex, pc_sel,
    output fwd_a, fwd_b, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard / sequencing controller for the 5-stage integer core.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - hazard_ctrl_if.slave. Stage fields come in. Stall, flush, bubble,
//           pc_sel, forwarding selects, FSM state and the saturating
//           stall/flush counters go out.
// Control outputs are combinational from the registered state and the
// current inputs.
//
// state   | meaning
// RUN     | normal issue; resolves branch, MUL start and load-use in that order
// MULBUSY | MUL held in EX; stalls until the down-counter reaches 0
// FLUSH   | second cycle of a taken branch; redirects the PC to the target
module hazard_ctrl #(
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 16
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MULBUSY = 2'b01,
    FLUSH   = 2'b10
  } state_t;

  // The cycle spent in RUN counts as the first MUL cycle and the release
  // cycle counts as the last one, so the counter starts at MUL_LATENCY-2.
  localparam logic [3:0] MUL_LOAD = (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 2) : 4'd0;
  localparam bit         MUL_STALLS = (MUL_LATENCY > 1);

  state_t           state_q, state_d;
  logic [3:0]       mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             flush_inc;
  logic             load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (bus.mem_valid && bus.mem_reg_write && bus.mem_rd != 5'd0 && bus.mem_rd == src)
      return 2'b01;
    else if (bus.wb_valid && bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == src)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign load_use = bus.ex_valid && bus.ex_mem_read && bus.ex_rd != 5'd0 && bus.id_valid &&
                    (bus.ex_rd == bus.id_rs || (bus.id_uses_rt && bus.ex_rd == bus.id_rt));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      mul_cnt_q   <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      if (!bus.pc_write && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d          = state_q;
    mul_cnt_d        = mul_cnt_q;
    flush_inc        = 1'b0;
    bus.stall_flag   = 1'b0;
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.flush_if_id  = 1'b0;
    bus.bubble_id_ex = 1'b0;
    bus.pc_sel       = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.br_taken) begin
          bus.flush_if_id  = 1'b1;
          bus.bubble_id_ex = 1'b1;
          flush_inc        = 1'b1;
          state_d          = FLUSH;
        end else if (bus.ex_valid && bus.ex_is_mul && MUL_STALLS) begin
          bus.stall_flag  = 1'b1;
          bus.pc_write    = 1'b0;
          bus.if_id_write = 1'b0;
          mul_cnt_d       = MUL_LOAD;
          state_d         = MULBUSY;
        end else if (load_use) begin
          bus.pc_write     = 1'b0;
          bus.if_id_write  = 1'b0;
          bus.bubble_id_ex = 1'b1;
        end
      end
      MULBUSY: begin
        if (mul_cnt_q != 4'd0) begin
          bus.stall_flag  = 1'b1;
          bus.pc_write    = 1'b0;
          bus.if_id_write = 1'b0;
          mul_cnt_d       = mul_cnt_q - 4'd1;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        bus.pc_sel       = 1'b1;
        bus.flush_if_id  = 1'b1;
        bus.bubble_id_ex = 1'b1;
        state_d          = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.fwd_a     = fwd_sel(bus.ex_rs);
  assign bus.fwd_b     = fwd_sel(bus.ex_rt);
  assign bus.state     = state_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. The main instance uses
// MUL_LATENCY=3; a second instance with MUL_LATENCY=1 covers the no-stall case.
module tb_hazard_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hazard_ctrl_if #(.CNT_W(16)) bus ();
  hazard_ctrl_if #(.CNT_W(16)) bus1 ();

  hazard_ctrl #(.MUL_LATENCY(3), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  hazard_ctrl #(.MUL_LATENCY(1), .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0;
    bus.ex_valid = 0; bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_rd = 0;
    bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_is_mul = 0; bus.br_taken = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_reg_write = 0;
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_reg_write = 0;
    bus1.id_valid = 0; bus1.id_rs = 0; bus1.id_rt = 0; bus1.id_uses_rt = 0;
    bus1.ex_valid = 0; bus1.ex_rs = 0; bus1.ex_rt = 0; bus1.ex_rd = 0;
    bus1.ex_reg_write = 0; bus1.ex_mem_read = 0; bus1.ex_is_mul = 0; bus1.br_taken = 0;
    bus1.mem_valid = 0; bus1.mem_rd = 0; bus1.mem_reg_write = 0;
    bus1.wb_valid = 0; bus1.wb_rd = 0; bus1.wb_reg_write = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.stall_flag, bus.pc_write, bus.if_id_write, bus.flush_if_id, bus.bubble_id_ex, bus.pc_sel} !== 6'b011000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 011000",
               {bus.stall_flag, bus.pc_write, bus.if_id_write, bus.flush_if_id, bus.bubble_id_ex, bus.pc_sel});
    end
    checks++;
    if ({bus.fwd_a, bus.fwd_b, bus.state} !== 6'b000000) begin
      errors++; $display("FAIL reset_fwd_state: got %b expected 000000", {bus.fwd_a, bus.fwd_b, bus.state});
    end
    // start a MUL, then reset while in MULBUSY
    bus.ex_valid = 1; bus.ex_is_mul = 1;
    tick();
    checks++;
    if (bus.state !== 2'b01) begin
      errors++; $display("FAIL reset_pre_mulbusy: state got %b expected 01", bus.state);
    end
    clear_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.state, bus.stall_flag, bus.pc_write} !== 4'b0001) begin
      errors++; $display("FAIL reset_async: state/stall/pcw got %b expected 0001", {bus.state, bus.stall_flag, bus.pc_write});
    end
    checks++;
    if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.stall_cnt, bus.flush_cnt);
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_load_use();
    do_reset();
    bus.ex_valid = 1; bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_rd = 5;
    bus.id_valid = 1; bus.id_rs = 3; bus.id_rt = 5; bus.id_uses_rt = 1;
    #1;
    checks++;
    if ({bus.pc_write, bus.if_id_write, bus.bubble_id_ex, bus.stall_flag} !== 4'b0010) begin
      errors++; $display("FAIL load_use_stall: pcw/ifw/bub/stall got %b expected 0010",
                         {bus.pc_write, bus.if_id_write, bus.bubble_id_ex, bus.stall_flag});
    end
    tick();
    // the load has moved to MEM; the dependent instruction proceeds
    bus.ex_valid = 0; bus.ex_mem_read = 0;
    #1;
    checks++;
    if (bus.stall_cnt !== 16'd1 || bus.pc_write !== 1'b1) begin
      errors++; $display("FAIL load_use_one_cycle: stall_cnt=%0d pc_write=%b expected 1 and 1", bus.stall_cnt, bus.pc_write);
    end
    // rt not read: no hazard
    bus.ex_valid = 1; bus.ex_mem_read = 1; bus.id_uses_rt = 0;
    #1;
    checks++;
    if ({bus.pc_write, bus.bubble_id_ex} !== 2'b10) begin
      errors++; $display("FAIL load_use_no_rt: pcw/bub got %b expected 10", {bus.pc_write, bus.bubble_id_ex});
    end
    // destination r0: no hazard
    bus.ex_rd = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 1;
    #1;
    checks++;
    if ({bus.pc_write, bus.bubble_id_ex} !== 2'b10) begin
      errors++; $display("FAIL load_use_r0: pcw/bub got %b expected 10", {bus.pc_write, bus.bubble_id_ex});
    end
    tick();
    checks++;
    if (bus.stall_cnt !== 16'd1) begin
      errors++; $display("FAIL load_use_cnt_hold: stall_cnt got %0d expected 1", bus.stall_cnt);
    end
  endtask

  task automatic test_mul();
    int stalls;
    do_reset();
    bus.ex_valid = 1; bus.ex_is_mul = 1;
    #1;
    checks++;
    if ({bus.state, bus.stall_flag, bus.pc_write, bus.bubble_id_ex} !== 5'b00100) begin
      errors++; $display("FAIL mul_c0: state/stall/pcw/bub got %b expected 00100", {bus.state, bus.stall_flag, bus.pc_write, bus.bubble_id_ex});
    end
    tick();
    checks++;
    if ({bus.state, bus.stall_flag, bus.if_id_write} !== 4'b0110) begin
      errors++; $display("FAIL mul_c1: state/stall/ifw got %b expected 0110", {bus.state, bus.stall_flag, bus.if_id_write});
    end
    tick();
    checks++;
    if ({bus.state, bus.stall_flag, bus.pc_write} !== 4'b0101) begin
      errors++; $display("FAIL mul_c2_release: state/stall/pcw got %b expected 0101", {bus.state, bus.stall_flag, bus.pc_write});
    end
    bus.ex_valid = 0; bus.ex_is_mul = 0;
    tick();
    checks++;
    if (bus.state !== 2'b00 || bus.stall_cnt !== 16'd2) begin
      errors++; $display("FAIL mul_done: state=%b stall_cnt=%0d expected 00 and 2", bus.state, bus.stall_cnt);
    end
    // two MULs back to back: EX holds a MUL for 6 cycles
    do_reset();
    bus.ex_valid = 1; bus.ex_is_mul = 1;
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.stall_flag) stalls++;
      tick();
    end
    bus.ex_valid = 0; bus.ex_is_mul = 0;
    #1;
    checks++;
    if (stalls !== 4 || bus.stall_cnt !== 16'd4) begin
      errors++; $display("FAIL mul_back_to_back: stalls=%0d stall_cnt=%0d expected 4 and 4", stalls, bus.stall_cnt);
    end
    // MUL_LATENCY=1 instance never stalls
    do_reset();
    bus1.ex_valid = 1; bus1.ex_is_mul = 1;
    #1;
    checks++;
    if ({bus1.stall_flag, bus1.pc_write} !== 2'b01) begin
      errors++; $display("FAIL mul_lat1: stall/pcw got %b expected 01", {bus1.stall_flag, bus1.pc_write});
    end
    tick();
    checks++;
    if (bus1.state !== 2'b00 || bus1.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL mul_lat1_state: state=%b stall_cnt=%0d expected 00 and 0", bus1.state, bus1.stall_cnt);
    end
    bus1.ex_valid = 0; bus1.ex_is_mul = 0;
  endtask

  task automatic test_branch();
    do_reset();
    bus.br_taken = 1; bus.ex_valid = 1; bus.ex_is_mul = 1;
    #1;
    checks++;
    if ({bus.flush_if_id, bus.bubble_id_ex, bus.stall_flag, bus.pc_write, bus.pc_sel} !== 5'b11010) begin
      errors++; $display("FAIL br_c0: flush/bub/stall/pcw/pcsel got %b expected 11010",
                         {bus.flush_if_id, bus.bubble_id_ex, bus.stall_flag, bus.pc_write, bus.pc_sel});
    end
    tick();
    bus.ex_valid = 0; bus.ex_is_mul = 0;
    #1;
    checks++;
    if ({bus.state, bus.pc_sel, bus.flush_if_id, bus.bubble_id_ex} !== 5'b10111 || bus.flush_cnt !== 16'd1) begin
      errors++; $display("FAIL br_c1: state/pcsel/flush/bub got %b flush_cnt=%0d expected 10111 and 1",
                         {bus.state, bus.pc_sel, bus.flush_if_id, bus.bubble_id_ex}, bus.flush_cnt);
    end
    tick();
    checks++;
    if (bus.state !== 2'b00 || bus.flush_cnt !== 16'd1) begin
      errors++; $display("FAIL br_c2: state=%b flush_cnt=%0d expected 00 and 1", bus.state, bus.flush_cnt);
    end
    bus.br_taken = 0;
    tick();
    checks++;
    if (bus.flush_cnt !== 16'd1 || bus.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL br_no_second: flush_cnt=%0d stall_cnt=%0d expected 1 and 0", bus.flush_cnt, bus.stall_cnt);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    bus.mem_valid = 1; bus.mem_rd = 7; bus.mem_reg_write = 1;
    bus.wb_valid = 1; bus.wb_rd = 7; bus.wb_reg_write = 1;
    bus.ex_rs = 7; bus.ex_rt = 3;
    #1;
    checks++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b0100) begin
      errors++; $display("FAIL fwd_mem_prio: fwd_a/fwd_b got %b expected 0100", {bus.fwd_a, bus.fwd_b});
    end
    bus.mem_reg_write = 0;
    #1;
    checks++;
    if (bus.fwd_a !== 2'b10) begin
      errors++; $display("FAIL fwd_wb: fwd_a got %b expected 10", bus.fwd_a);
    end
    bus.mem_reg_write = 1; bus.mem_rd = 0; bus.wb_rd = 0; bus.ex_rt = 0; bus.ex_rs = 0;
    #1;
    checks++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) begin
      errors++; $display("FAIL fwd_r0: fwd_a/fwd_b got %b expected 0000", {bus.fwd_a, bus.fwd_b});
    end
    bus.mem_rd = 9; bus.mem_valid = 0; bus.wb_rd = 9; bus.ex_rt = 9;
    #1;
    checks++;
    if (bus.fwd_b !== 2'b10) begin
      errors++; $display("FAIL fwd_b_mem_invalid: fwd_b got %b expected 10", bus.fwd_b);
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    bus.ex_valid = 1; bus.ex_mem_read = 1; bus.ex_rd = 4;
    bus.id_valid = 1; bus.id_rs = 4;
    repeat (65534) tick();
    checks++;
    if (bus.stall_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL sat_before: stall_cnt got %h expected fffe", bus.stall_cnt);
    end
    repeat (5) tick();
    checks++;
    if (bus.stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold: stall_cnt got %h expected ffff", bus.stall_cnt);
    end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    clear_inputs();
    #12;
    test_reset();
    test_load_use();
    test_mul();
    test_branch();
    test_forwarding();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencer for the 5-stage integer core. It sits beside the ID/EX/MEM/WB registers and owns four jobs:
- generates stall_flag, which freezes the EX stage, plus the upstream write enables;
- inserts ID/EX bubbles and IF/ID flushes;
- selects operand forwarding for EX;
- holds a multi-cycle MUL in EX for MUL_LATENCY cycles.
It also keeps saturating stall/flush performance counters.

Parameters:
MUL_LATENCY, 3, total cycles a MUL occupies EX; legal values are 1 to 16, and 1 means no MUL stall.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs  in  5  ID source register 1
id_rt  in  5  ID source register 2
id_uses_rt  in  1  ID instruction reads rt (R-type, BEQ, SW)
ex_valid  in  1  EX holds a real instruction
ex_rs  in  5  EX source register 1
ex_rt  in  5  EX source register 2
ex_rd  in  5  EX destination, after reg_dst mux
ex_reg_write  in  1  EX instruction writes the register file
ex_mem_read  in  1  EX instruction is LW
ex_is_mul  in  1  EX instruction is R-type MUL
br_taken  in  1  EX branch resolved taken (branch and zero)
mem_valid  in  1  MEM holds a real instruction
mem_rd  in  5  MEM destination register
mem_reg_write  in  1  MEM instruction writes the register file
wb_valid  in  1  WB holds a real instruction
wb_rd  in  5  WB destination register
wb_reg_write  in  1  WB instruction writes the register file
stall_flag  out  1  freeze EX (and ID/EX) this cycle
pc_write  out  1  PC may update
if_id_write  out  1  IF/ID may load
flush_if_id  out  1  clear IF/ID valid
bubble_id_ex  out  1  load NOP into ID/EX
pc_sel  out  1  1 = next PC taken from EX pcout (branch target)
fwd_a  out  2  EX operand A source: 00 register file, 01 MEM, 10 WB
fwd_b  out  2  EX operand B source, same encoding as fwd_a
state  out  2  FSM state: 00 RUN, 01 MULBUSY, 10 FLUSH
stall_cnt  out  CNT_W  cycles with pc_write equal to 0, saturating
flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Control outputs are combinational from the registered state and the current inputs. The state, the MUL down-counter (4 bit) and the performance counters are registered on the rising edge of clk.
- Reset values:
  - state is RUN; MUL counter and both performance counters are 0.
  - With no valid inputs: stall_flag=0, pc_write=1, if_id_write=1, flush_if_id=0, bubble_id_ex=0, pc_sel=0, fwd_a=fwd_b=00.
- Reset asserted mid-MULBUSY or mid-FLUSH aborts the sequence immediately and returns to RUN.
- Defaults in any state: pc_write=1, if_id_write=1, all other control outputs 0.
- RUN, in priority order:
  1. br_taken=1: flush_if_id=1 and bubble_id_ex=1; next state FLUSH; flush_cnt+1. Any MUL or load-use condition in the same cycle is ignored.
  2. ex_valid and ex_is_mul with MUL_LATENCY>1: stall_flag=1, pc_write=0, if_id_write=0, bubble_id_ex=0; load counter with MUL_LATENCY-2; next state MULBUSY.
  3. Load-use hazard, defined as ex_valid and ex_mem_read and ex_rd!=0 and id_valid and (ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt)): pc_write=0, if_id_write=0, bubble_id_ex=1, stall_flag=0; stay in RUN. This is exactly one stall cycle per load-use pair.
- MULBUSY:
  - Counter not 0: stall_flag=1, pc_write=0, if_id_write=0; counter decrements.
  - Counter equal to 0: all stalls release and next state is RUN, so the MUL leaves EX at this edge.
  - Total EX residence is exactly MUL_LATENCY cycles, with MUL_LATENCY-1 stall cycles.
  - br_taken and load-use are ignored in this state.
  - A back-to-back MUL re-enters MULBUSY from RUN.
- FLUSH, exactly one cycle: pc_sel=1, flush_if_id=1, bubble_id_ex=1; br_taken ignored; next state RUN.
- Forwarding is active in every state and computed identically for A (ex_rs) and B (ex_rt):
  - 01 if mem_valid and mem_reg_write and mem_rd!=0 and mem_rd equals the source register;
  - otherwise 10 if the same test passes on the WB fields;
  - otherwise 00.
  - MEM has priority over WB; register 0 never forwards.
- stall_cnt increments every cycle pc_write=0. Both counters saturate at all-ones and do not wrap.

Test Plan:
1. Reset asserted while in MULBUSY -> state=00, stall_flag=0, pc_write=1, both counters 0, in the same cycle (asynchronous).
2. LW r5 in EX (ex_mem_read=1, ex_rd=5) with ID reading id_rt=5, id_uses_rt=1 -> one cycle of pc_write=0, if_id_write=0, bubble_id_ex=1; stall_cnt=1. Repeat with id_uses_rt=0 -> no stall. Repeat with ex_rd=0 -> no stall.
3. MUL in EX, MUL_LATENCY=3 -> stall_flag=1 for exactly 2 cycles, state sequence RUN, MULBUSY, RUN, stall_cnt=2. Back-to-back MULs -> 4 stall cycles. With MUL_LATENCY=1 -> no stall.
4. br_taken=1 in RUN -> cycle 0: flush_if_id=1 and bubble_id_ex=1; cycle 1: pc_sel=1 with state=10; cycle 2: state RUN; flush_cnt=1. br_taken held high during FLUSH -> no second flush.
5. Forwarding: mem_rd=wb_rd=7 with both reg_write=1 and ex_rs=7 -> fwd_a=01. Same with mem_reg_write=0 -> fwd_a=10. Same with ex_rt=0 and rd=0 -> fwd_b=00.
6. Saturation: force 2^CNT_W+3 stall cycles -> stall_cnt holds at 0xFFFF for CNT_W=16.
